// File: rtl/iso_domain_seq.sv
// Power-domain isolation sequencer: one FSM per switchable domain orders
// isolate -> power off -> power on -> settle -> release, and clamps the domain's bus slice.
module iso_domain_fsm #(
  parameter int ISO_SETUP  = 2,
  parameter int PWR_SETTLE = 4,
  parameter int ACK_TMO    = 16,
  parameter int CW         = 5
) (
  input  logic ck,
  input  logic arst,
  input  logic off_req,
  input  logic on_req,
  input  logic pwr_ack,
  input  logic err_clr,
  output logic iso_en,
  output logic pwr_en,
  output logic dom_on,
  output logic dom_off,
  output logic err
);
  typedef enum logic [2:0] {S_ON, S_ISO, S_OFF_WAIT, S_OFF, S_ON_WAIT, S_SETTLE} state_t;

  localparam logic [CW-1:0] ISO_LD = CW'(ISO_SETUP - 1);
  localparam logic [CW-1:0] SET_LD = CW'(PWR_SETTLE - 1);
  localparam logic [CW-1:0] TMO    = CW'(ACK_TMO);
  localparam logic [CW-1:0] TMO_M1 = CW'(ACK_TMO - 1);

  state_t        state;
  logic [CW-1:0] cnt;
  logic          in_wait, ack_missing, tmo, bad_req, pwr_fault, new_err;

  always_comb begin
    in_wait     = (state == S_OFF_WAIT) || (state == S_ON_WAIT);
    ack_missing = (state == S_OFF_WAIT) ? pwr_ack : !pwr_ack;
    tmo         = in_wait && ack_missing && (cnt == TMO_M1);
    bad_req     = (off_req || on_req) && (state != S_ON) && (state != S_OFF);
    // ack level disagreeing with a settled state means the switch moved on its own
    pwr_fault   = ((state == S_ON) && !pwr_ack) || ((state == S_OFF) && pwr_ack);
    new_err     = tmo || bad_req || pwr_fault;
  end

  assign dom_on  = (state == S_ON);
  assign dom_off = (state == S_OFF);

  always_ff @(posedge ck) begin
    if (!arst) begin
      state  <= S_ON;
      iso_en <= 1'b0;
      pwr_en <= 1'b1;
      err    <= 1'b0;
      cnt    <= '0;
    end else begin
      err <= new_err || (err && !err_clr);
      case (state)
        S_ON:
          if (off_req) begin
            state  <= S_ISO;
            iso_en <= 1'b1;
            cnt    <= ISO_LD;
          end
        S_ISO:
          if (cnt == '0) begin
            state  <= S_OFF_WAIT;
            pwr_en <= 1'b0;
          end else cnt <= cnt - CW'(1);
        S_OFF_WAIT:
          if (!pwr_ack) begin
            state <= S_OFF;
            cnt   <= '0;
          end else if (cnt != TMO) cnt <= cnt + CW'(1);
        S_OFF:
          if (on_req) begin
            state  <= S_ON_WAIT;
            pwr_en <= 1'b1;
            cnt    <= '0;
          end
        S_ON_WAIT:
          if (pwr_ack) begin
            state <= S_SETTLE;
            cnt   <= SET_LD;
          end else if (cnt != TMO) cnt <= cnt + CW'(1);
        S_SETTLE:
          if (cnt == '0) begin
            state  <= S_ON;
            iso_en <= 1'b0;
          end else cnt <= cnt - CW'(1);
        default: begin
          state  <= S_ON;
          iso_en <= 1'b0;
          pwr_en <= 1'b1;
          cnt    <= '0;
        end
      endcase
    end
  end
endmodule

module iso_domain_seq #(
  parameter int                   NDOM       = 3,
  parameter int                   DW         = 8,
  parameter logic [NDOM*DW-1:0]   CLAMP_VAL  = '0,
  parameter int                   ISO_SETUP  = 2,
  parameter int                   PWR_SETTLE = 4,
  parameter int                   ACK_TMO    = 16
) (
  input  logic                 ck,
  input  logic                 arst,
  input  logic [NDOM-1:0]      off_req,
  input  logic [NDOM-1:0]      on_req,
  input  logic [NDOM-1:0]      pwr_ack,
  input  logic                 err_clr,
  input  logic [NDOM*DW-1:0]   d_in,
  output logic [NDOM*DW-1:0]   d_out,
  output logic [NDOM-1:0]      iso_en,
  output logic [NDOM-1:0]      pwr_en,
  output logic [NDOM-1:0]      dom_on,
  output logic [NDOM-1:0]      dom_off,
  output logic [NDOM-1:0]      err
);
  localparam int CMAX = (ISO_SETUP > PWR_SETTLE)
                        ? ((ISO_SETUP > ACK_TMO) ? ISO_SETUP : ACK_TMO)
                        : ((PWR_SETTLE > ACK_TMO) ? PWR_SETTLE : ACK_TMO);
  localparam int CW = $clog2(CMAX + 1);
  localparam logic [NDOM-1:0][DW-1:0] CLAMP_V = CLAMP_VAL;

  logic [NDOM-1:0][DW-1:0] din_v, dout_v;

  assign din_v = d_in;
  assign d_out = dout_v;

  for (genvar i = 0; i < NDOM; i++) begin : g_dom
    iso_domain_fsm #(
      .ISO_SETUP (ISO_SETUP),
      .PWR_SETTLE(PWR_SETTLE),
      .ACK_TMO   (ACK_TMO),
      .CW        (CW)
    ) u_fsm (
      .ck     (ck),
      .arst   (arst),
      .off_req(off_req[i]),
      .on_req (on_req[i]),
      .pwr_ack(pwr_ack[i]),
      .err_clr(err_clr),
      .iso_en (iso_en[i]),
      .pwr_en (pwr_en[i]),
      .dom_on (dom_on[i]),
      .dom_off(dom_off[i]),
      .err    (err[i])
    );
    assign dout_v[i] = iso_en[i] ? CLAMP_V[i] : din_v[i];
  end
endmodule

// File: tb/tb_iso_domain_seq.sv
// Bench for iso_domain_seq: cycle table through a scoreboard queue, then
// hand-written sequences for timeout, illegal request, mid-sequence reset and power loss.
module tb_iso_domain_seq;
  localparam logic [23:0] CLAMP = 24'hC3_5A_3C;
  localparam logic [23:0] DIN   = 24'h33_A5_77;

  logic        ck = 1'b0;
  logic        arst, err_clr;
  logic [2:0]  off_req, on_req, pwr_ack;
  logic [23:0] d_in, d_out;
  logic [2:0]  iso_en, pwr_en, dom_on, dom_off, err;

  always #5 ck = ~ck;

  iso_domain_seq #(
    .NDOM(3), .DW(8), .CLAMP_VAL(CLAMP),
    .ISO_SETUP(2), .PWR_SETTLE(4), .ACK_TMO(16)
  ) dut (
    .ck(ck), .arst(arst), .off_req(off_req), .on_req(on_req), .pwr_ack(pwr_ack),
    .err_clr(err_clr), .d_in(d_in), .d_out(d_out), .iso_en(iso_en), .pwr_en(pwr_en),
    .dom_on(dom_on), .dom_off(dom_off), .err(err)
  );

  typedef struct {
    logic [2:0] off, on, ack;
    logic       clr;
    logic [2:0] iso, pwr, don, doff, er;
    logic [23:0] dout;
  } vec_t;

  typedef struct {
    logic [2:0]  iso, pwr, don, doff, er;
    logic [23:0] dout;
  } exp_t;

  vec_t tbl[$];
  exp_t sbq[$];
  int   n_vec = 0, n_bad = 0;

  function automatic vec_t V(input logic [2:0] off, on, ack, input logic clr,
                             input logic [2:0] iso, pwr, don, doff, er, input logic [23:0] dout);
    vec_t v;
    v.off = off; v.on = on; v.ack = ack; v.clr = clr;
    v.iso = iso; v.pwr = pwr; v.don = don; v.doff = doff; v.er = er; v.dout = dout;
    return v;
  endfunction

  task automatic tick(input logic [2:0] off, on, ack, input logic clr);
    @(negedge ck);
    off_req = off; on_req = on; pwr_ack = ack; err_clr = clr;
    @(posedge ck);
    #1;
  endtask

  task automatic chk(input string name, input logic [23:0] act, input logic [23:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    arst = 1'b0;
    tick(3'b000, 3'b000, 3'b111, 1'b0);
    tick(3'b000, 3'b000, 3'b111, 1'b0);
    arst = 1'b1;
  endtask

  initial begin
    exp_t e;
    arst = 1'b0; err_clr = 1'b0; off_req = '0; on_req = '0; pwr_ack = 3'b111; d_in = DIN;

    // domain 1 full off/on, pwr_ack lagging pwr_en by one cycle
    tbl.push_back(V(3'b000, 3'b000, 3'b111, 0, 3'b000, 3'b111, 3'b111, 3'b000, 3'b000, 24'h33A577));
    tbl.push_back(V(3'b010, 3'b000, 3'b111, 0, 3'b010, 3'b111, 3'b101, 3'b000, 3'b000, 24'h335A77));
    tbl.push_back(V(3'b000, 3'b000, 3'b111, 0, 3'b010, 3'b111, 3'b101, 3'b000, 3'b000, 24'h335A77));
    tbl.push_back(V(3'b000, 3'b000, 3'b111, 0, 3'b010, 3'b101, 3'b101, 3'b000, 3'b000, 24'h335A77));
    tbl.push_back(V(3'b000, 3'b000, 3'b111, 0, 3'b010, 3'b101, 3'b101, 3'b000, 3'b000, 24'h335A77));
    tbl.push_back(V(3'b000, 3'b000, 3'b101, 0, 3'b010, 3'b101, 3'b101, 3'b010, 3'b000, 24'h335A77));
    tbl.push_back(V(3'b000, 3'b000, 3'b101, 0, 3'b010, 3'b101, 3'b101, 3'b010, 3'b000, 24'h335A77));
    tbl.push_back(V(3'b000, 3'b010, 3'b101, 0, 3'b010, 3'b111, 3'b101, 3'b000, 3'b000, 24'h335A77));
    tbl.push_back(V(3'b000, 3'b000, 3'b101, 0, 3'b010, 3'b111, 3'b101, 3'b000, 3'b000, 24'h335A77));
    for (int i = 0; i < 4; i++)
      tbl.push_back(V(3'b000, 3'b000, 3'b111, 0, 3'b010, 3'b111, 3'b101, 3'b000, 3'b000, 24'h335A77));
    tbl.push_back(V(3'b000, 3'b000, 3'b111, 0, 3'b000, 3'b111, 3'b111, 3'b000, 3'b000, 24'h33A577));
    // domain 0: both requests in ON (off wins), off_req alone in OFF, both in OFF (on wins)
    tbl.push_back(V(3'b001, 3'b001, 3'b111, 0, 3'b001, 3'b111, 3'b110, 3'b000, 3'b000, 24'h33A53C));
    tbl.push_back(V(3'b000, 3'b000, 3'b111, 0, 3'b001, 3'b111, 3'b110, 3'b000, 3'b000, 24'h33A53C));
    tbl.push_back(V(3'b000, 3'b000, 3'b111, 0, 3'b001, 3'b110, 3'b110, 3'b000, 3'b000, 24'h33A53C));
    tbl.push_back(V(3'b000, 3'b000, 3'b111, 0, 3'b001, 3'b110, 3'b110, 3'b000, 3'b000, 24'h33A53C));
    tbl.push_back(V(3'b000, 3'b000, 3'b110, 0, 3'b001, 3'b110, 3'b110, 3'b001, 3'b000, 24'h33A53C));
    tbl.push_back(V(3'b001, 3'b000, 3'b110, 0, 3'b001, 3'b110, 3'b110, 3'b001, 3'b000, 24'h33A53C));
    tbl.push_back(V(3'b001, 3'b001, 3'b110, 0, 3'b001, 3'b111, 3'b110, 3'b000, 3'b000, 24'h33A53C));
    tbl.push_back(V(3'b000, 3'b000, 3'b110, 0, 3'b001, 3'b111, 3'b110, 3'b000, 3'b000, 24'h33A53C));
    for (int i = 0; i < 4; i++)
      tbl.push_back(V(3'b000, 3'b000, 3'b111, 0, 3'b001, 3'b111, 3'b110, 3'b000, 3'b000, 24'h33A53C));
    tbl.push_back(V(3'b000, 3'b000, 3'b111, 0, 3'b000, 3'b111, 3'b111, 3'b000, 3'b000, 24'h33A577));

    // reset defaults
    tick(3'b000, 3'b000, 3'b111, 1'b0);
    tick(3'b000, 3'b000, 3'b111, 1'b0);
    arst = 1'b1;
    chk("rst iso_en", 24'(iso_en), 24'(3'b000));
    chk("rst pwr_en", 24'(pwr_en), 24'(3'b111));
    chk("rst dom_on", 24'(dom_on), 24'(3'b111));
    chk("rst err",    24'(err),    24'(3'b000));
    chk("rst d_out",  d_out,       DIN);

    foreach (tbl[i]) begin
      @(negedge ck);
      off_req = tbl[i].off; on_req = tbl[i].on; pwr_ack = tbl[i].ack; err_clr = tbl[i].clr;
      e.iso = tbl[i].iso; e.pwr = tbl[i].pwr; e.don = tbl[i].don;
      e.doff = tbl[i].doff; e.er = tbl[i].er; e.dout = tbl[i].dout;
      sbq.push_back(e);
      @(posedge ck);
      #1;
      e = sbq.pop_front();
      n_vec++;
      if ({iso_en, pwr_en, dom_on, dom_off, err, d_out} !== {e.iso, e.pwr, e.don, e.doff, e.er, e.dout}) begin
        n_bad++;
        $display("FAIL vec%0d: got iso=%b pwr=%b on=%b off=%b err=%b dout=%h want iso=%b pwr=%b on=%b off=%b err=%b dout=%h",
                 i, iso_en, pwr_en, dom_on, dom_off, err, d_out, e.iso, e.pwr, e.don, e.doff, e.er, e.dout);
      end
    end

    // on_req while domain 2 is in ISO
    do_reset();
    tick(3'b100, 3'b000, 3'b111, 1'b0);
    chk("ill iso_en", 24'(iso_en), 24'(3'b100));
    tick(3'b000, 3'b100, 3'b111, 1'b0);
    chk("ill err", 24'(err), 24'(3'b100));
    tick(3'b000, 3'b000, 3'b111, 1'b0);
    chk("ill pwr_en", 24'(pwr_en), 24'(3'b011));
    tick(3'b000, 3'b000, 3'b011, 1'b0);
    chk("ill dom_off", 24'(dom_off), 24'(3'b100));
    chk("ill err held", 24'(err), 24'(3'b100));

    // ack timeout on domain 0; err_clr coincides with the timeout edge
    do_reset();
    tick(3'b001, 3'b000, 3'b111, 1'b0);
    tick(3'b000, 3'b000, 3'b111, 1'b0);
    tick(3'b000, 3'b000, 3'b111, 1'b0);
    chk("tmo wait pwr_en", 24'(pwr_en), 24'(3'b110));
    for (int i = 0; i < 15; i++) tick(3'b000, 3'b000, 3'b111, 1'b0);
    chk("tmo early err", 24'(err), 24'(3'b000));
    tick(3'b000, 3'b000, 3'b111, 1'b1);
    chk("tmo err vs clr", 24'(err), 24'(3'b001));
    tick(3'b000, 3'b000, 3'b111, 1'b1);
    chk("tmo clr after sat", 24'(err), 24'(3'b000));
    tick(3'b000, 3'b000, 3'b110, 1'b0);
    chk("tmo dom_off", 24'(dom_off), 24'(3'b001));
    chk("tmo no err", 24'(err), 24'(3'b000));

    // reset while domain 0 is in SETTLE
    do_reset();
    tick(3'b001, 3'b000, 3'b111, 1'b0);
    tick(3'b000, 3'b000, 3'b111, 1'b0);
    tick(3'b000, 3'b000, 3'b111, 1'b0);
    tick(3'b000, 3'b000, 3'b110, 1'b0);
    tick(3'b000, 3'b001, 3'b110, 1'b0);
    tick(3'b000, 3'b000, 3'b111, 1'b0);
    tick(3'b000, 3'b000, 3'b111, 1'b0);
    chk("settle iso_en", 24'(iso_en), 24'(3'b001));
    chk("settle dom_on", 24'(dom_on), 24'(3'b110));
    arst = 1'b0;
    tick(3'b000, 3'b000, 3'b111, 1'b0);
    arst = 1'b1;
    chk("midrst pwr_en", 24'(pwr_en), 24'(3'b111));
    chk("midrst iso_en", 24'(iso_en), 24'(3'b000));
    chk("midrst dom_on", 24'(dom_on), 24'(3'b111));

    // unexpected power loss on domain 0 while ON
    tick(3'b000, 3'b000, 3'b111, 1'b0);
    chk("loss pre err", 24'(err), 24'(3'b000));
    tick(3'b000, 3'b000, 3'b110, 1'b0);
    chk("loss err", 24'(err), 24'(3'b001));
    chk("loss dom_on", 24'(dom_on), 24'(3'b111));
    tick(3'b000, 3'b000, 3'b110, 1'b1);
    chk("loss refire vs clr", 24'(err), 24'(3'b001));
    tick(3'b000, 3'b000, 3'b111, 1'b1);
    chk("loss cleared", 24'(err), 24'(3'b000));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
